// File: rtl/fetch_issue_reg_if.sv
// Fetch-buffer / decode bundle around the fetch-to-issue register.
// slave = the register's view, master = the surrounding pipeline's view.
interface fetch_issue_reg_if;
    logic        fifo_valid;
    logic [31:0] fifo_inst0;
    logic [31:0] fifo_inst1;
    logic [31:0] fifo_pc;
    logic [31:0] fifo_pc_next;
    logic [31:0] fifo_badv;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag;
    logic [1:0]  fifo_priv_flag;
    logic        fifo_allowin;
    logic [1:0]  id_issue_cnt;
    logic        id_valid0;
    logic        id_valid1;
    logic [31:0] id_inst0;
    logic [31:0] id_inst1;
    logic [31:0] id_pc0;
    logic [31:0] id_pc1;
    logic [31:0] id_badv;
    logic [6:0]  id_exception;
    logic [1:0]  id_excp_flag;
    logic [1:0]  id_priv_flag;

    modport slave (
        input  fifo_valid, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
        input  fifo_badv, fifo_exception, fifo_excp_flag, fifo_priv_flag,
        input  id_issue_cnt,
        output fifo_allowin,
        output id_valid0, id_valid1, id_inst0, id_inst1, id_pc0, id_pc1,
        output id_badv, id_exception, id_excp_flag, id_priv_flag
    );

    modport master (
        output fifo_valid, fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next,
        output fifo_badv, fifo_exception, fifo_excp_flag, fifo_priv_flag,
        output id_issue_cnt,
        input  fifo_allowin,
        input  id_valid0, id_valid1, id_inst0, id_inst1, id_pc0, id_pc1,
        input  id_badv, id_exception, id_excp_flag, id_priv_flag
    );
endinterface

// File: rtl/fetch_issue_reg.sv
// Two-slot fetch-to-decode register with slot compaction and flush.
// Define FETCH_ISSUE_PERF_EN to enable the bubble/split perf counters.
module fetch_issue_reg #(
    parameter logic [31:0] NOP_INST = 32'h0340_0000,
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    fetch_issue_reg_if.slave    bus,
    output logic [31:0]         perf_bubble_cnt,
    output logic [31:0]         perf_split_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } cnt_e;

    cnt_e        r_cnt;
    cnt_e        w_cnt_nxt;

    logic [31:0] r_inst0;
    logic [31:0] r_inst1;
    logic [31:0] r_pc0;
    logic [31:0] r_pc1;
    logic [31:0] r_badv;
    logic [6:0]  r_exc;
    logic [1:0]  r_ef;
    logic [1:0]  r_pf;

    logic [1:0]  w_take;
    logic        w_allowin;
    logic        w_load;
    logic        w_drain;
    logic        w_shift;
    logic        w_in_two;
    logic [31:0] w_pc_p4;

    assign w_take    = (bus.id_issue_cnt > r_cnt) ? r_cnt : bus.id_issue_cnt;
    assign w_allowin = !flush && (w_take == r_cnt);
    assign w_load    = w_allowin && bus.fifo_valid;
    assign w_drain   = w_allowin && !bus.fifo_valid;
    assign w_shift   = !flush && (r_cnt == S_TWO) && (w_take == 2'd1);
    assign w_pc_p4   = bus.fifo_pc + 32'd4;

    // A faulting packet only carries its first slot to decode.
    assign w_in_two  = (bus.fifo_excp_flag == 2'b00) &&
                       (bus.fifo_pc_next == bus.fifo_pc + 32'd8);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_cnt <= S_EMPTY;
        else       r_cnt <= w_cnt_nxt;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (flush)
            w_cnt_nxt = S_EMPTY;
        else if (w_load)
            w_cnt_nxt = w_in_two ? S_TWO : S_ONE;
        else if (w_allowin)
            w_cnt_nxt = S_EMPTY;
        else if (w_shift)
            w_cnt_nxt = S_ONE;
    end

    always_comb begin
        bus.fifo_allowin = w_allowin;
        bus.id_valid0    = (r_cnt != S_EMPTY);
        bus.id_valid1    = (r_cnt == S_TWO);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inst0 <= NOP_INST;
            r_inst1 <= NOP_INST;
            r_pc0   <= RESET_PC;
            r_pc1   <= RESET_PC;
            r_badv  <= RESET_PC;
            r_exc   <= '0;
            r_ef    <= '0;
            r_pf    <= '0;
        end else begin
            unique case (1'b1)
                flush: begin
                    r_inst0 <= NOP_INST;
                    r_inst1 <= NOP_INST;
                    r_pc0   <= RESET_PC;
                    r_pc1   <= RESET_PC;
                    r_badv  <= '0;
                    r_exc   <= '0;
                    r_ef    <= '0;
                    r_pf    <= '0;
                end
                w_load: begin
                    r_inst0 <= bus.fifo_inst0;
                    r_inst1 <= w_in_two ? bus.fifo_inst1 : NOP_INST;
                    r_pc0   <= bus.fifo_pc;
                    r_pc1   <= w_pc_p4;
                    r_badv  <= bus.fifo_badv;
                    r_exc   <= bus.fifo_exception;
                    r_ef    <= bus.fifo_excp_flag;
                    r_pf    <= bus.fifo_priv_flag;
                end
                w_drain: begin
                    r_inst0 <= NOP_INST;
                    r_inst1 <= NOP_INST;
                    r_pc0   <= RESET_PC;
                    r_pc1   <= RESET_PC;
                end
                w_shift: begin
                    r_inst0 <= r_inst1;
                    r_pc0   <= r_pc1;
                    r_inst1 <= NOP_INST;
                    r_pc1   <= RESET_PC;
                end
                default: ;
            endcase
        end
    end

    assign bus.id_inst0     = r_inst0;
    assign bus.id_inst1     = r_inst1;
    assign bus.id_pc0       = r_pc0;
    assign bus.id_pc1       = r_pc1;
    assign bus.id_badv      = r_badv;
    assign bus.id_exception = r_exc;
    assign bus.id_excp_flag = r_ef;
    assign bus.id_priv_flag = r_pf;

`ifdef FETCH_ISSUE_PERF_EN
    logic [31:0] r_bubble;
    logic [31:0] r_split;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bubble <= '0;
            r_split  <= '0;
        end else begin
            if (r_cnt == S_EMPTY && !flush && r_bubble != '1)
                r_bubble <= r_bubble + 32'd1;
            if (w_load && !w_in_two && r_split != '1)
                r_split <= r_split + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble;
    assign perf_split_cnt  = r_split;
`else
    assign perf_bubble_cnt = '0;
    assign perf_split_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_issue_reg.sv
// Randomized bench for fetch_issue_reg against a slot-queue model.
// Build with FETCH_ISSUE_PERF_EN to also check the perf counters.
module tb_fetch_issue_reg;

    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam logic [31:0] RPC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_split_cnt;

    fetch_issue_reg_if bus();

    fetch_issue_reg #(.NOP_INST(NOP), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .flush           (flush),
        .bus             (bus),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_split_cnt  (perf_split_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: decode-visible slots in order, plus sideband of the last packet.
    logic [31:0] m_inst[$];
    logic [31:0] m_pc[$];
    logic [31:0] m_badv;
    logic [6:0]  m_exc;
    logic [1:0]  m_ef;
    logic [1:0]  m_pf;
    logic [31:0] m_bub;
    logic [31:0] m_spl;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inst.delete();
        m_pc.delete();
        m_badv = RPC;
        m_exc  = '0;
        m_ef   = '0;
        m_pf   = '0;
        m_bub  = '0;
        m_spl  = '0;
    endtask

    task automatic check_reset();
        chk("rst_valid0", bus.id_valid0, 0);
        chk("rst_valid1", bus.id_valid1, 0);
        chk("rst_inst0", bus.id_inst0, NOP);
        chk("rst_inst1", bus.id_inst1, NOP);
        chk("rst_pc0", bus.id_pc0, RPC);
        chk("rst_pc1", bus.id_pc1, RPC);
        chk("rst_badv", bus.id_badv, RPC);
        chk("rst_exc", bus.id_exception, 0);
        chk("rst_ef", bus.id_excp_flag, 0);
        chk("rst_pf", bus.id_priv_flag, 0);
        chk("rst_bubble", perf_bubble_cnt, 0);
        chk("rst_split", perf_split_cnt, 0);
    endtask

    task automatic compare();
        int n;
        n = m_inst.size();
        chk("valid0", bus.id_valid0, n >= 1);
        chk("valid1", bus.id_valid1, n == 2);
        if (n >= 1) begin
            chk("inst0", bus.id_inst0, m_inst[0]);
            chk("pc0", bus.id_pc0, m_pc[0]);
            chk("badv", bus.id_badv, m_badv);
            chk("exc", bus.id_exception, m_exc);
            chk("ef", bus.id_excp_flag, m_ef);
            chk("pf", bus.id_priv_flag, m_pf);
        end else begin
            chk("empty_inst0", bus.id_inst0, NOP);
            chk("empty_pc0", bus.id_pc0, RPC);
        end
        if (n == 2) begin
            chk("inst1", bus.id_inst1, m_inst[1]);
            chk("pc1", bus.id_pc1, m_pc[1]);
        end
`ifdef FETCH_ISSUE_PERF_EN
        chk("bubble", perf_bubble_cnt, m_bub);
        chk("split", perf_split_cnt, m_spl);
`else
        chk("bubble_off", perf_bubble_cnt, 0);
        chk("split_off", perf_split_cnt, 0);
`endif
    endtask

    // One clock: check the pop decision, advance the model, check outputs.
    task automatic step();
        int take;
        int n;
        logic al;
        #1;
        n    = m_inst.size();
        take = (int'(bus.id_issue_cnt) > n) ? n : int'(bus.id_issue_cnt);
        al   = !flush && (take == n);
        chk("allowin", bus.fifo_allowin, al);
        if (n == 0 && !flush && m_bub != '1) m_bub++;
        if (flush) begin
            m_inst.delete();
            m_pc.delete();
            m_badv = '0;
            m_exc  = '0;
            m_ef   = '0;
            m_pf   = '0;
        end else begin
            repeat (take) begin
                void'(m_inst.pop_front());
                void'(m_pc.pop_front());
            end
            if (al && bus.fifo_valid) begin
                m_inst.push_back(bus.fifo_inst0);
                m_pc.push_back(bus.fifo_pc);
                if (bus.fifo_excp_flag == 0 &&
                    bus.fifo_pc_next == bus.fifo_pc + 32'd8) begin
                    m_inst.push_back(bus.fifo_inst1);
                    m_pc.push_back(bus.fifo_pc + 32'd4);
                end else if (m_spl != '1) begin
                    m_spl++;
                end
                m_badv = bus.fifo_badv;
                m_exc  = bus.fifo_exception;
                m_ef   = bus.fifo_excp_flag;
                m_pf   = bus.fifo_priv_flag;
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_pkt(input logic v, input logic [31:0] pc,
                           input logic [31:0] pcn, input logic [1:0] ef,
                           input logic [6:0] exc, input logic [1:0] iss,
                           input logic fl);
        bus.fifo_valid     = v;
        bus.fifo_inst0     = 32'hAAAA_0000 ^ pc;
        bus.fifo_inst1     = 32'hBBBB_0000 ^ pc;
        bus.fifo_pc        = pc;
        bus.fifo_pc_next   = pcn;
        bus.fifo_badv      = pc ^ 32'h0000_0F00;
        bus.fifo_exception = exc;
        bus.fifo_excp_flag = ef;
        bus.fifo_priv_flag = pc[3:2];
        bus.id_issue_cnt   = iss;
        flush              = fl;
    endtask

    task automatic rand_pkt();
        logic [31:0] pc;
        logic [31:0] pcn;
        int r;
        pc = $urandom() & 32'hFFFF_FFFC;
        r  = $urandom_range(0, 3);
        pcn = (r < 2) ? pc + 32'd8 : (r == 2) ? pc + 32'd4 : $urandom();
        set_pkt($urandom_range(0, 9) < 7, pc, pcn,
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                7'($urandom()), 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0);
        bus.fifo_inst0 = $urandom();
        bus.fifo_inst1 = $urandom();
    endtask

    initial begin
        model_reset();
        set_pkt(1'b0, 32'h0, 32'h0, 2'b00, 7'h0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rstn = 1'b1;

        set_pkt(1'b1, 32'h1C00_0000, 32'h1C00_0008, 2'b00, 7'h0, 2'd2, 1'b0);
        step();
        set_pkt(1'b0, 32'h0, 32'h0, 2'b00, 7'h0, 2'd2, 1'b0);
        step();
        step();

        set_pkt(1'b1, 32'h1C00_0000, 32'h1C00_0008, 2'b00, 7'h0, 2'd1, 1'b0);
        step();
        set_pkt(1'b1, 32'h1C00_0010, 32'h1C00_0018, 2'b00, 7'h0, 2'd1, 1'b0);
        step();
        step();

        set_pkt(1'b1, 32'h1C00_0020, 32'h1C00_0024, 2'b00, 7'h0, 2'd2, 1'b0);
        step();
        set_pkt(1'b1, 32'h1C00_0030, 32'h1C00_0038, 2'b01, 7'h08, 2'd2, 1'b0);
        step();
        set_pkt(1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 2'b00, 7'h0, 2'd2, 1'b0);
        step();

        set_pkt(1'b1, 32'h1C00_0040, 32'h1C00_0048, 2'b00, 7'h0, 2'd0, 1'b1);
        step();
        set_pkt(1'b1, 32'h1C00_0040, 32'h1C00_0048, 2'b00, 7'h0, 2'd0, 1'b0);
        step();
        step();

        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_reset();
        flush = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rand_pkt();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
